// File: rtl/ra_display_pkg.sv
// Shared types and constants for the rolling-average digit display:
// 7-segment digit table, display state encoding and digit width.
package ra_display_pkg;

   localparam int DIGIT_W = 4;
   localparam int SEG_W   = 7;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // Active-high segments, bit0 = a ... bit6 = g.
   localparam logic [SEG_W-1:0] SEG_DIGIT [10] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
   };

   typedef enum logic [1:0] {
      BLANK = 2'd0,
      TENS  = 2'd1,
      UNITS = 2'd2
   } disp_state_t;

   function automatic logic [SEG_W-1:0] seg_encode(input logic [DIGIT_W-1:0] digit);
      if (digit > 4'd9) return SEG_BLANK;
      return SEG_DIGIT[digit];
   endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Iterative double-dabble: one add-3/shift step per clock, BITS steps per value.
// done and the digit outputs are valid combinationally during the final step.
module bin2bcd_serial
   import ra_display_pkg::*;
#(
   parameter int BITS = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [BITS-1:0]    bin,
   output logic               busy,
   output logic               done,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] units
);

   localparam int CNT_W = $clog2(BITS + 1);

   logic [BITS-1:0]          r_bin;
   logic [2*DIGIT_W-1:0]     r_bcd;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_busy;

   logic [DIGIT_W-1:0]       w_tens_adj;
   logic [DIGIT_W-1:0]       w_units_adj;
   logic [2*DIGIT_W-1:0]     w_bcd_shift;

   assign w_tens_adj  = (r_bcd[7:4] >= 4'd5) ? r_bcd[7:4] + 4'd3 : r_bcd[7:4];
   assign w_units_adj = (r_bcd[3:0] >= 4'd5) ? r_bcd[3:0] + 4'd3 : r_bcd[3:0];
   assign w_bcd_shift = {w_tens_adj[DIGIT_W-2:0], w_units_adj, r_bin[BITS-1]};

   assign busy  = r_busy;
   assign done  = r_busy && (r_cnt == CNT_W'(1));
   assign tens  = w_bcd_shift[7:4];
   assign units = w_bcd_shift[3:0];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bin  <= '0;
         r_bcd  <= '0;
         r_cnt  <= '0;
         r_busy <= 1'b0;
      end else if (start && !r_busy) begin
         r_bin  <= bin;
         r_bcd  <= '0;
         r_cnt  <= CNT_W'(BITS);
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_bin <= r_bin << 1;
         r_bcd <= w_bcd_shift;
         r_cnt <= r_cnt - CNT_W'(1);
         if (r_cnt == CNT_W'(1)) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ra_digit_display.sv
// Converts the rolling average to two decimal digits and time-multiplexes them
// onto one registered 7-segment output; the decimal point marks the tens digit.
module ra_digit_display
   import ra_display_pkg::*;
#(
   parameter int BITS_PER_ELEM      = 5,
   parameter int DWELL_CYCLES       = 1024,
   parameter int BLANK_LEADING_ZERO = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [BITS_PER_ELEM-1:0] i_ra,
   input  logic                     i_ra_valid,
   output logic [SEG_W-1:0]         o_seg,
   output logic                     o_dp,
   output logic                     o_busy
);

   localparam int CNT_W = $clog2(DWELL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam bit SKIP_ZERO = (BLANK_LEADING_ZERO != 0);

   logic [BITS_PER_ELEM-1:0] r_pend_val;
   logic                     r_pend;
   logic [DIGIT_W-1:0]       r_tens;
   logic [DIGIT_W-1:0]       r_units;
   logic [CNT_W-1:0]         r_cnt;
   disp_state_t              r_state;

   logic                     w_busy;
   logic                     w_done;
   logic                     w_start;
   logic [BITS_PER_ELEM-1:0] w_start_val;
   logic [DIGIT_W-1:0]       w_conv_tens;
   logic [DIGIT_W-1:0]       w_conv_units;
   logic                     w_term;
   disp_state_t              w_state_nxt;
   logic [DIGIT_W-1:0]       w_tens_nxt;
   logic [DIGIT_W-1:0]       w_units_nxt;
   logic [CNT_W-1:0]         w_cnt_nxt;
   logic [SEG_W-1:0]         w_seg_nxt;
   logic                     w_dp_nxt;

   // A held pending value takes priority; a strobe in that cycle refills pending.
   assign w_start     = !w_busy && (r_pend || i_ra_valid);
   assign w_start_val = r_pend ? r_pend_val : i_ra;
   assign w_term      = (r_cnt == CNT_LAST);
   assign o_busy      = w_busy;

   bin2bcd_serial #(
      .BITS (BITS_PER_ELEM)
   ) u_bin2bcd (
      .clk   (clk),
      .rst   (rst),
      .start (w_start),
      .bin   (w_start_val),
      .busy  (w_busy),
      .done  (w_done),
      .tens  (w_conv_tens),
      .units (w_conv_units)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend     <= 1'b0;
         r_pend_val <= '0;
      end else if (w_busy && i_ra_valid) begin
         r_pend     <= 1'b1;
         r_pend_val <= i_ra;
      end else if (!w_busy && r_pend) begin
         r_pend <= i_ra_valid;
         if (i_ra_valid) r_pend_val <= i_ra;
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      w_tens_nxt  = r_tens;
      w_units_nxt = r_units;
      w_cnt_nxt   = r_cnt;
      if (w_done) begin
         w_tens_nxt  = w_conv_tens;
         w_units_nxt = w_conv_units;
         w_cnt_nxt   = '0;
         w_state_nxt = (SKIP_ZERO && w_conv_tens == '0) ? UNITS : TENS;
      end else begin
         unique case (r_state)
            TENS: begin
               if (w_term) begin
                  w_cnt_nxt   = '0;
                  w_state_nxt = UNITS;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            UNITS: begin
               if (w_term) begin
                  w_cnt_nxt = '0;
                  if (!(SKIP_ZERO && r_tens == '0)) w_state_nxt = TENS;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs are decoded from next-state so the registered pins change with the state.
   always_comb begin
      w_seg_nxt = SEG_BLANK;
      w_dp_nxt  = 1'b0;
      unique case (w_state_nxt)
         TENS: begin
            w_seg_nxt = seg_encode(w_tens_nxt);
            w_dp_nxt  = 1'b1;
         end
         UNITS:   w_seg_nxt = seg_encode(w_units_nxt);
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= BLANK;
         r_tens  <= '0;
         r_units <= '0;
         r_cnt   <= '0;
         o_seg   <= SEG_BLANK;
         o_dp    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tens  <= w_tens_nxt;
         r_units <= w_units_nxt;
         r_cnt   <= w_cnt_nxt;
         o_seg   <= w_seg_nxt;
         o_dp    <= w_dp_nxt;
      end
   end

endmodule

// File: tb/tb_ra_digit_display.sv
// Directed bench for ra_digit_display: two instances share stimulus, one with
// leading-zero blanking enabled and one without, both with a 4-cycle dwell.
module tb_ra_digit_display;

   localparam int BITS  = 5;
   localparam int DWELL = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [BITS-1:0] i_ra;
   logic            i_ra_valid;
   logic [6:0]      o_seg1, o_seg0;
   logic            o_dp1, o_dp0;
   logic            o_busy1, o_busy0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ra_digit_display #(
      .BITS_PER_ELEM      (BITS),
      .DWELL_CYCLES       (DWELL),
      .BLANK_LEADING_ZERO (1)
   ) u_dut_blz (
      .clk        (clk),
      .rst        (rst),
      .i_ra       (i_ra),
      .i_ra_valid (i_ra_valid),
      .o_seg      (o_seg1),
      .o_dp       (o_dp1),
      .o_busy     (o_busy1)
   );

   ra_digit_display #(
      .BITS_PER_ELEM      (BITS),
      .DWELL_CYCLES       (DWELL),
      .BLANK_LEADING_ZERO (0)
   ) u_dut_nob (
      .clk        (clk),
      .rst        (rst),
      .i_ra       (i_ra),
      .i_ra_valid (i_ra_valid),
      .o_seg      (o_seg0),
      .o_dp       (o_dp0),
      .o_busy     (o_busy0)
   );

   function automatic logic [6:0] enc(input int d);
      case (d)
         0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
         4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
         8: return 7'h7F;  9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   // Expected {dp, seg} m cycles after the first cycle showing new digits.
   function automatic logic [7:0] exp_disp(input int t, input int u, input bit blz, input int m);
      if (blz && t == 0) return {1'b0, enc(u)};
      if (((m / DWELL) % 2) == 0) return {1'b1, enc(t)};
      return {1'b0, enc(u)};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      i_ra = '0;
      i_ra_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if ({o_busy1, o_dp1, o_seg1} !== 9'h000 || {o_busy0, o_dp0, o_seg0} !== 9'h000) begin
            errors++;
            $display("FAIL reset_idle cycle %0d: blz busy/dp/seg=%b/%b/%h nob=%b/%b/%h, required 0/0/00",
                     k, o_busy1, o_dp1, o_seg1, o_busy0, o_dp0, o_seg0);
         end
      end
   endtask

   task automatic test_single_value(input int v, input int t, input int u, input bit blank_before);
      logic [7:0] e1, e0;
      @(posedge clk);
      #1 i_ra = BITS'(v);
      i_ra_valid = 1'b1;
      @(posedge clk);
      #1 i_ra_valid = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         checks++;
         if (o_busy1 !== (k <= 5) || o_busy0 !== (k <= 5)) begin
            errors++;
            $display("FAIL busy_%0d cycle N+%0d: got %b/%b, required %b", v, k, o_busy1, o_busy0, k <= 5);
         end
         if (k <= 5 && blank_before) begin
            checks++;
            if ({o_dp1, o_seg1} !== 8'h00 || {o_dp0, o_seg0} !== 8'h00) begin
               errors++;
               $display("FAIL blank_during_conv_%0d cycle N+%0d: got %h/%h, required 00",
                        v, k, {o_dp1, o_seg1}, {o_dp0, o_seg0});
            end
         end
         if (k >= 6) begin
            e1 = exp_disp(t, u, 1'b1, k - 6);
            e0 = exp_disp(t, u, 1'b0, k - 6);
            checks++;
            if ({o_dp1, o_seg1} !== e1) begin
               errors++;
               $display("FAIL disp_blz_%0d cycle N+%0d: dp/seg got %b/%h, required %b/%h",
                        v, k, o_dp1, o_seg1, e1[7], e1[6:0]);
            end
            checks++;
            if ({o_dp0, o_seg0} !== e0) begin
               errors++;
               $display("FAIL disp_nob_%0d cycle N+%0d: dp/seg got %b/%h, required %b/%h",
                        v, k, o_dp0, o_seg0, e0[7], e0[6:0]);
            end
         end
      end
   endtask

   // 12 converts first; 20 then 31 arrive while busy, so only 31 follows.
   task automatic test_back_to_back();
      logic [7:0] e1;
      bit         busy_exp;
      @(posedge clk);
      #1 i_ra = BITS'(12);
      i_ra_valid = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         i_ra_valid = (k == 2) || (k == 3);
         if (k == 2) i_ra = BITS'(20);
         if (k == 3) i_ra = BITS'(31);
         @(negedge clk);
         busy_exp = (k >= 1 && k <= 5) || (k >= 7 && k <= 11);
         checks++;
         if (o_busy1 !== busy_exp || o_busy0 !== busy_exp) begin
            errors++;
            $display("FAIL b2b_busy cycle N+%0d: got %b/%b, required %b", k, o_busy1, o_busy0, busy_exp);
         end
         if (k >= 6) begin
            e1 = (k < 12) ? exp_disp(1, 2, 1'b1, k - 6) : exp_disp(3, 1, 1'b1, k - 12);
            checks++;
            if ({o_dp1, o_seg1} !== e1 || {o_dp0, o_seg0} !== e1) begin
               errors++;
               $display("FAIL b2b_disp cycle N+%0d: got %h/%h, required %h",
                        k, {o_dp1, o_seg1}, {o_dp0, o_seg0}, e1);
            end
         end
      end
   endtask

   task automatic test_reset_mid_conversion();
      logic [7:0] e1;
      @(posedge clk);
      #1 i_ra = BITS'(12);
      i_ra_valid = 1'b1;
      @(posedge clk);
      #1 i_ra_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1 i_ra = BITS'(27);
      i_ra_valid = 1'b1;
      @(posedge clk);
      #1 i_ra = BITS'(20);
      @(posedge clk);
      #1 i_ra_valid = 1'b0;
      @(negedge clk);
      e1 = exp_disp(1, 2, 1'b1, 9);
      checks++;
      if (o_busy1 !== 1'b1 || {o_dp1, o_seg1} !== e1 || {o_dp0, o_seg0} !== e1) begin
         errors++;
         $display("FAIL pre_reset: busy %b disp %h/%h, required 1 and %h",
                  o_busy1, {o_dp1, o_seg1}, {o_dp0, o_seg0}, e1);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({o_busy1, o_dp1, o_seg1} !== 9'h000 || {o_busy0, o_dp0, o_seg0} !== 9'h000) begin
         errors++;
         $display("FAIL async_reset: busy/dp/seg %b/%b/%h and %b/%b/%h, required all 0",
                  o_busy1, o_dp1, o_seg1, o_busy0, o_dp0, o_seg0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if ({o_busy1, o_dp1, o_seg1} !== 9'h000 || {o_busy0, o_dp0, o_seg0} !== 9'h000) begin
            errors++;
            $display("FAIL post_reset_idle cycle %0d: busy/dp/seg %b/%b/%h, required 0/0/00",
                     k, o_busy1, o_dp1, o_seg1);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_value(27, 2, 7, 1'b1);
      test_single_value(5, 0, 5, 1'b0);
      test_single_value(0, 0, 0, 1'b0);
      test_single_value(31, 3, 1, 1'b0);
      test_back_to_back();
      test_reset_mid_conversion();
      test_single_value(31, 3, 1, 1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
